qupls_regfile_wrport: RTL and testbench



---
 rtl/qupls_regfile_wrport_pkg.sv | 14 +
 rtl/qupls_regfile_wrport_rr_arbiter.sv | 31 +++
 rtl/qupls_regfile_wrport.sv | 110 +++++++++++
 tb/tb_qupls_regfile_wrport.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/qupls_regfile_wrport_pkg.sv
// Minimal stand-ins for the shared CPU type packages, plus the write-port FSM state.
// Only the items used by the register-file write port are defined here.
package cpu_types_pkg;
  typedef logic [63:0] value_t;
endpackage

package QuplsPkg;
  localparam int PREGS = 64;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } wrport_state_t;
endpackage

// File: rtl/qupls_regfile_wrport_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr.
// Produces both a one-hot grant and its index.
module qupls_rr_arbiter #(
  parameter int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic          w_found;
  logic [IW-1:0] w_idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = IW'((int'(ptr) + k) % N);
      if (!w_found && req[w_idx]) begin
        w_found      = 1'b1;
        gnt[w_idx]   = 1'b1;
        gnt_idx      = w_idx;
      end
    end
  end

endmodule

// File: rtl/qupls_regfile_wrport.sv
// Register-file write port: zero-sweeps the RAM after reset, then round-robin
// arbitrates writeback sources onto the single registered RAM write port.
module qupls_regfile_wrport
  import QuplsPkg::*;
#(
  parameter int  NSRC = 4,
  parameter int  WID  = $bits(cpu_types_pkg::value_t) + 1,
  parameter int  DEP  = PREGS,
  localparam int RBIT = $clog2(DEP) - 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NSRC-1:0]                src_valid,
  output logic [NSRC-1:0]                src_ready,
  input  logic [NSRC-1:0][RBIT:0]        src_addr,
  input  logic [NSRC-1:0][WID-1:0]       src_data,
  output logic                           rf_ena,
  output logic                           rf_wea,
  output logic [RBIT:0]                  rf_addra,
  output logic [WID-1:0]                 rf_dina,
  output logic                           wb_valid,
  output logic [RBIT:0]                  wb_addr,
  output logic [WID-1:0]                 wb_data,
  output logic                           busy
);

  localparam int            IW       = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam logic [RBIT:0] LAST_REG = (RBIT+1)'(DEP - 1);
  localparam logic [IW-1:0] LAST_SRC = IW'(NSRC - 1);

  wrport_state_t  r_state, w_state_nxt;
  logic [RBIT:0]  r_clr_cnt;
  logic [IW-1:0]  r_rr;
  logic           r_wea;
  logic [RBIT:0]  r_addr;
  logic [WID-1:0] r_data;

  logic [NSRC-1:0] w_gnt;
  logic [IW-1:0]   w_gnt_idx;
  logic            w_run;
  logic            w_hs;
  logic [RBIT:0]   w_sel_addr;
  logic [WID-1:0]  w_sel_data;
  logic            w_wr;
  logic [RBIT:0]   w_waddr;
  logic [WID-1:0]  w_wdata;

  qupls_rr_arbiter #(.N(NSRC)) u_arb (
    .req     (src_valid),
    .ptr     (r_rr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  assign w_run      = (r_state == RUN);
  assign src_ready  = w_run ? w_gnt : '0;
  assign w_hs       = |src_ready;
  assign w_sel_addr = src_addr[w_gnt_idx];
  assign w_sel_data = src_data[w_gnt_idx];

  // Handshakes to the zero register are consumed without touching the RAM.
  always_comb begin
    w_state_nxt = r_state;
    w_wr        = 1'b0;
    w_waddr     = r_clr_cnt;
    w_wdata     = '0;
    case (r_state)
      CLEAR: begin
        w_wr = 1'b1;
        if (r_clr_cnt == LAST_REG) w_state_nxt = RUN;
      end
      RUN: begin
        w_waddr = w_sel_addr;
        w_wdata = w_sel_data;
        w_wr    = w_hs && (w_sel_addr != '0);
      end
      default: w_state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= CLEAR;
      r_clr_cnt <= '0;
      r_rr      <= '0;
      r_wea     <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == CLEAR) r_clr_cnt <= r_clr_cnt + 1'b1;
      if (w_hs) r_rr <= (w_gnt_idx == LAST_SRC) ? '0 : w_gnt_idx + IW'(1);
      r_wea <= w_wr;
      if (w_wr) begin
        r_addr <= w_waddr;
        r_data <= w_wdata;
      end
    end
  end

  assign rf_ena   = r_wea;
  assign rf_wea   = r_wea;
  assign rf_addra = r_addr;
  assign rf_dina  = r_data;
  assign wb_valid = r_wea;
  assign wb_addr  = r_addr;
  assign wb_data  = r_data;
  assign busy     = ~w_run;

endmodule

// File: tb/tb_qupls_regfile_wrport.sv
// Bench for qupls_regfile_wrport: cycle model of sweep + round-robin rules,
// per-cycle compare, and directed scenarios with literal expectations.
module tb_qupls_regfile_wrport;
  localparam int NSRC = 4, WID = 65, DEP = 64, RBIT = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NSRC-1:0]          src_valid, src_ready;
  logic [NSRC-1:0][RBIT:0]  src_addr;
  logic [NSRC-1:0][WID-1:0] src_data;
  logic                     rf_ena, rf_wea, wb_valid, busy;
  logic [RBIT:0]            rf_addra, wb_addr;
  logic [WID-1:0]           rf_dina, wb_data;

  qupls_regfile_wrport #(.NSRC(NSRC), .WID(WID), .DEP(DEP)) dut (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_ready(src_ready),
    .src_addr(src_addr), .src_data(src_data), .rf_ena(rf_ena), .rf_wea(rf_wea),
    .rf_addra(rf_addra), .rf_dina(rf_dina), .wb_valid(wb_valid),
    .wb_addr(wb_addr), .wb_data(wb_data), .busy(busy)
  );

  int errors = 0, checks = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---- behavioural model ----
  int             m_idx = 0;   // sweep writes issued so far
  int             m_rr  = 0;
  int             mg, cg;
  logic           mv = 1'b0;
  logic [RBIT:0]  ma = '0;
  logic [WID-1:0] md = '0;
  logic [NSRC-1:0] er;

  function automatic int pick(input logic [NSRC-1:0] v, input int rr);
    for (int k = 0; k < NSRC; k++)
      if (v[(rr + k) % NSRC]) return (rr + k) % NSRC;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_idx = 0; m_rr = 0; mv = 1'b0; ma = '0; md = '0;
    end else if (m_idx < DEP) begin
      mv = 1'b1; ma = m_idx[RBIT:0]; md = '0; m_idx++;
    end else begin
      mg = pick(src_valid, m_rr);
      mv = 1'b0;
      if (mg >= 0) begin
        m_rr = (mg + 1) % NSRC;
        if (src_addr[mg] != '0) begin
          mv = 1'b1; ma = src_addr[mg]; md = src_data[mg];
        end
      end
    end
  end

  // Bench-side RAM and write log fed from the DUT's write port.
  logic [WID-1:0] ram [DEP];
  int             wqa[$];
  logic [WID-1:0] wqd[$];

  always @(negedge clk) begin
    if (chk_en) begin
      er = '0;
      if (m_idx >= DEP) begin
        cg = pick(src_valid, m_rr);
        if (cg >= 0) er[cg] = 1'b1;
      end
      chk("src_ready", src_ready, er);
      chk("busy", busy, m_idx < DEP);
      chk("rf_wea", rf_wea, mv);
      chk("rf_ena", rf_ena, mv);
      chk("wb_valid", wb_valid, mv);
      if (mv) begin
        chk("rf_addra", rf_addra, ma);
        chk("rf_dina", rf_dina, md);
        chk("wb_addr", wb_addr, ma);
        chk("wb_data", wb_data, md);
      end
    end
    if (rf_wea) begin
      ram[rf_addra] = rf_dina;
      wqa.push_back(int'(rf_addra));
      wqd.push_back(rf_dina);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic sweep(input string nm);
    int n, bad;
    n = 0;
    while (busy && n < 200) begin step(); n++; end
    chk({nm, "_done"}, n < 200, 1'b1);
    @(negedge clk); #1;
    chk({nm, "_count"}, wqa.size(), DEP);
    bad = 0;
    for (int i = 0; i < wqa.size(); i++)
      if (wqa[i] != i || wqd[i] != '0) bad++;
    chk({nm, "_addrs"}, bad, 0);
  endtask

  initial begin
    int n, bad;
    src_valid = '0; src_addr = '0; src_data = '0;
    #3;
    chk("rst_wea", rf_wea, 1'b0);
    chk("rst_addr", rf_addra, '0);
    chk("rst_data", rf_dina, '0);
    chk("rst_wbv", wb_valid, 1'b0);
    chk("rst_busy", busy, 1'b1);
    chk("rst_ready", src_ready, '0);
    chk_en = 1'b1;
    // sweep while a source is already requesting: it must not be granted
    src_valid = 4'b0001; src_addr[0] = 6'd7; src_data[0] = 65'h7;
    step(); step();
    wqa.delete(); wqd.delete();
    rst = 1'b0;
    sweep("sweep1");
    src_valid = '0;
    step(); step();

    // all four sources valid from rr=0
    for (int i = 0; i < NSRC; i++) begin
      src_addr[i] = RBIT'(10 + i);
      src_data[i] = 65'h100 + i;
    end
    wqa.delete(); wqd.delete();
    src_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #3 chk("rr_grant", src_ready, 4'b0001 << (k % 4));
      step();
    end
    src_valid = '0;
    step(); #4;
    chk("rr_nwrites", wqa.size(), 8);
    bad = 0;
    for (int k = 0; k < wqa.size(); k++)
      if (wqa[k] != 10 + (k % 4)) bad++;
    chk("rr_order", bad, 0);
    step();

    // single source 2 -> addr 5, data 0x1_DEAD
    src_valid = 4'b0100; src_addr[2] = 6'd5; src_data[2] = 65'h1_DEAD;
    #3 chk("s2_ready", src_ready, 4'b0100);
    step();
    src_valid = '0;
    #3;
    chk("s2_wea", rf_wea, 1'b1);
    chk("s2_addr", rf_addra, 6'd5);
    chk("s2_data", rf_dina, 65'h1_DEAD);
    chk("s2_wbv", wb_valid, 1'b1);
    step();

    // source 1 to zero register: accepted, rr -> 2, no write
    src_valid = 4'b0010; src_addr[1] = 6'd0; src_data[1] = 65'h55;
    #3 chk("z_ready", src_ready, 4'b0010);
    step();
    src_valid = 4'b1111; src_addr[1] = 6'd11;
    #3;
    chk("z_nowrite", rf_wea, 1'b0);
    chk("z_rr2", src_ready, 4'b0100);
    step();
    src_valid = '0;
    step();

    // sources 0 and 3 to addr 9; rr=3 so 3 goes first, 0 wins
    src_addr[0] = 6'd9; src_data[0] = 65'h0_AAAA;
    src_addr[3] = 6'd9; src_data[3] = 65'h1_BBBB;
    src_valid = 4'b1001;
    #3 chk("c_first", src_ready, 4'b1000);
    step();
    src_valid = 4'b0001;
    #3 chk("c_second", src_ready, 4'b0001);
    step();
    src_valid = '0;
    step(); step();
    chk("c_lastwins", ram[9], 65'h0_AAAA);

    // reset mid-sweep at address 20
    rst = 1'b1;
    step();
    rst = 1'b0;
    n = 0;
    while (!(rf_wea && rf_addra == 6'd20) && n < 100) begin step(); n++; end
    chk("mid_reach20", n < 100, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mid_wea", rf_wea, 1'b0);
    chk("mid_addr", rf_addra, '0);
    chk("mid_busy", busy, 1'b1);
    chk("mid_wbv", wb_valid, 1'b0);
    step();
    wqa.delete(); wqd.delete();
    rst = 1'b0;
    sweep("sweep2");
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule
